// File: rtl/rec_pkg.sv
// Shared types for the record round-robin arbiter.
//   rec_t        : 24-bit shared record {tag, payload.x, payload.y}
//   WM_*         : bit positions of the per-field write mask
//   state_t      : arbiter sequencing states
//   apply_wmask  : merge of a new record into the current one under a field mask
package rec_pkg;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } payload_t;

    typedef struct packed {
        logic [7:0] tag;
        payload_t   payload;
    } rec_t;

    localparam int unsigned WM_TAG = 2;
    localparam int unsigned WM_X   = 1;
    localparam int unsigned WM_Y   = 0;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COMMIT
    } state_t;

    // Fields whose mask bit is clear keep their current value.
    function automatic rec_t apply_wmask(rec_t cur, rec_t nxt, logic [2:0] wm);
        rec_t r;
        r = cur;
        if (wm[WM_TAG]) r.tag       = nxt.tag;
        if (wm[WM_X])   r.payload.x = nxt.payload.x;
        if (wm[WM_Y])   r.payload.y = nxt.payload.y;
        return r;
    endfunction

endpackage

// File: rtl/rec_rr_arbiter_if.sv
// Requester/consumer bundle of the record arbiter.
//   req_valid/req_lock/req_rec/req_wmask : per-requester request side
//   req_ready                            : one-hot handshake ready
//   grant_valid/grant_id                 : current grant holder
//   rec_q/commit_valid/commit_count      : shared record and commit status
// slave modport is the arbiter side, master modport the requester/consumer side.
interface rec_rr_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 8
) ();
    import rec_pkg::*;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_lock;
    rec_t [NREQ-1:0]            req_rec;
    logic [NREQ-1:0][2:0]       req_wmask;
    logic [NREQ-1:0]            req_ready;
    logic                       grant_valid;
    logic [$clog2(NREQ)-1:0]    grant_id;
    rec_t                       rec_q;
    logic                       commit_valid;
    logic [CNT_W-1:0]           commit_count;

    modport slave (
        input  req_valid, req_lock, req_rec, req_wmask,
        output req_ready, grant_valid, grant_id, rec_q, commit_valid, commit_count
    );

    modport master (
        output req_valid, req_lock, req_rec, req_wmask,
        input  req_ready, grant_valid, grant_id, rec_q, commit_valid, commit_count
    );

endinterface

// File: rtl/rec_rr_pick.sv
// Combinational round-robin selector.
//   req_i    : request vector
//   ptr_i    : highest-priority index for this scan
//   winner_o : first set request at ptr_i, ptr_i+1, ... (mod NREQ)
//   any_o    : at least one request is set
module rec_rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [$clog2(NREQ)-1:0] winner_o,
    output logic                    any_o
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [ID_W-1:0] idx;
    logic            found;

    // NREQ is a power of two, so the modulo wrap is plain truncation.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr_i + ID_W'(k);
            if (!found && req_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/rec_rr_arbiter.sv
// Round-robin arbiter owning one shared record register.
//   clk, rst : clock and synchronous active-high reset
//   bus      : rec_rr_arbiter_if slave side (requests in; ready, grant,
//              shared record and commit status out)
// A granted requester commits its masked fields on a valid/ready transfer;
// a locked requester may keep the grant for up to MAX_BURST commits.
module rec_rr_arbiter
    import rec_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rec_rr_arbiter_if.slave      bus
);
    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam logic [3:0]  MAX_B = 4'(MAX_BURST);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [3:0]       burst_q, burst_d;
    logic             lock_q, lock_d;
    rec_t             shared_q, shared_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ID_W-1:0]  winner;
    logic             any_req;

    rec_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i    (bus.req_valid),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ptr_q      <= '0;
            burst_q    <= '0;
            lock_q     <= 1'b0;
            shared_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            burst_q    <= burst_d;
            lock_q     <= lock_d;
            shared_q   <= shared_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        burst_d    = burst_q;
        lock_d     = lock_q;
        shared_d   = shared_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d = winner;
                    burst_d    = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (bus.req_valid[grant_id_q]) begin
                    shared_d = apply_wmask(shared_q, bus.req_rec[grant_id_q],
                                           bus.req_wmask[grant_id_q]);
                    lock_d   = bus.req_lock[grant_id_q];
                    burst_d  = burst_q + 4'd1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = COMMIT;
                end else begin
                    // Withdrawal: the pointer stays so the same requester
                    // keeps priority when it comes back.
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                if (lock_q && bus.req_valid[grant_id_q] && (burst_q < MAX_B)) begin
                    state_d = GRANT;
                end else begin
                    ptr_d   = grant_id_q + ID_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == GRANT) bus.req_ready[grant_id_q] = bus.req_valid[grant_id_q];
    end

    assign bus.grant_valid  = (state_q == GRANT) || (state_q == COMMIT);
    assign bus.commit_valid = (state_q == COMMIT);
    assign bus.grant_id     = grant_id_q;
    assign bus.rec_q        = shared_q;
    assign bus.commit_count = cnt_q;

endmodule

// File: tb/tb_rec_rr_arbiter.sv
// Self-checking bench for rec_rr_arbiter: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_rec_rr_arbiter;
    import rec_pkg::*;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned CNT_W     = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rec_rr_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

    rec_rr_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who holds the grant, whether the holder has just
    // committed, how many beats it has taken, and the round-robin start.
    bit          m_busy;
    bit          m_done;
    bit          m_lock;
    int          m_id;
    int          m_ptr;
    int          m_beats;
    int          m_cnt;
    logic [23:0] m_rec;

    int          order[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_first(input logic [NREQ-1:0] v, input int from);
        for (int k = 0; k < int'(NREQ); k++)
            if (v[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_lock = 0;
        m_id = 0; m_ptr = 0; m_beats = 0; m_cnt = 0; m_rec = '0;
    endtask

    task automatic model_step();
        logic [23:0] n;
        logic [2:0]  w;
        int          win;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            win = rr_first(bus.req_valid, m_ptr);
            if (win >= 0) begin
                m_busy = 1; m_done = 0; m_id = win; m_beats = 0;
            end
        end else if (!m_done) begin
            if (bus.req_valid[m_id]) begin
                n = bus.req_rec[m_id];
                w = bus.req_wmask[m_id];
                if (w[2]) m_rec[23:16] = n[23:16];
                if (w[1]) m_rec[15:8]  = n[15:8];
                if (w[0]) m_rec[7:0]   = n[7:0];
                m_lock  = bus.req_lock[m_id];
                m_beats = m_beats + 1;
                m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                m_done  = 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_done = 0;
            if (!(m_lock && bus.req_valid[m_id] && m_beats < int'(MAX_BURST))) begin
                m_busy = 0;
                m_ptr  = (m_id + 1) % NREQ;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] er;
        er = '0;
        if (m_busy && !m_done && bus.req_valid[m_id]) er[m_id] = 1'b1;
        check("grant_valid",  64'(bus.grant_valid),  64'(m_busy));
        check("grant_id",     64'(bus.grant_id),     64'(m_id));
        check("commit_valid", 64'(bus.commit_valid), 64'(m_done));
        check("rec_q",        64'(bus.rec_q),        64'(m_rec));
        check("commit_count", 64'(bus.commit_count), 64'(m_cnt));
        check("req_ready",    64'(bus.req_ready),    64'(er));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        if (bus.commit_valid) order.push_back(int'(bus.grant_id));
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_rec   = '0;
        bus.req_wmask = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        order.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_rr[5];
        int exp_burst[5];
        exp_rr    = '{0, 1, 2, 3, 0};
        exp_burst = '{1, 1, 1, 1, 2};

        // Reset values
        do_reset();
        check("rst_grant_valid",  64'(bus.grant_valid),  64'd0);
        check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        check("rst_rec_q",        64'(bus.rec_q),        64'd0);
        check("rst_count",        64'(bus.commit_count), 64'd0);
        check("rst_ready",        64'(bus.req_ready),    64'd0);

        // Single full-mask transaction, then partial-mask update from req3
        bus.req_valid[0] = 1'b1;
        bus.req_rec[0]   = 24'h42AA55;
        bus.req_wmask[0] = 3'b111;
        cycle();
        check("t1_grant_id", 64'(bus.grant_id),  64'd0);
        check("t1_ready",    64'(bus.req_ready), 64'b0001);
        cycle();
        check("t1_rec_q",    64'(bus.rec_q),        64'h42AA55);
        check("t1_commit",   64'(bus.commit_valid), 64'd1);
        check("t1_count",    64'(bus.commit_count), 64'd1);
        idle();
        cycle();
        bus.req_valid[3] = 1'b1;
        bus.req_rec[3]   = 24'h00FF00;
        bus.req_wmask[3] = 3'b010;
        cycle();
        cycle();
        check("mask_rec_q", 64'(bus.rec_q), 64'h42FF55);
        idle();
        cycle();

        // All requesters valid, no lock: strict rotation
        do_reset();
        bus.req_valid = '1;
        bus.req_rec   = {24'h111111, 24'h222222, 24'h333333, 24'h444444};
        bus.req_wmask = '1;
        repeat (15) cycle();
        check("rr_count", 64'(bus.commit_count), 64'd5);
        for (int i = 0; i < 5; i++)
            check("rr_order", 64'((order.size() > i) ? order[i] : 99), 64'(exp_rr[i]));
        idle();

        // Locked burst from req1 with req2 waiting
        do_reset();
        bus.req_valid[1] = 1'b1;
        bus.req_lock[1]  = 1'b1;
        bus.req_valid[2] = 1'b1;
        bus.req_wmask    = '1;
        repeat (14) cycle();
        for (int i = 0; i < 5; i++)
            check("burst_order", 64'((order.size() > i) ? order[i] : 99), 64'(exp_burst[i]));
        idle();

        // Withdrawal keeps the pointer; reset wins mid-grant
        do_reset();
        bus.req_valid[2] = 1'b1;
        cycle();
        check("wd_grant_id", 64'(bus.grant_id), 64'd2);
        bus.req_valid[2] = 1'b0;
        cycle();
        check("wd_commit", 64'(bus.commit_valid), 64'd0);
        check("wd_count",  64'(bus.commit_count), 64'd0);
        check("wd_gvalid", 64'(bus.grant_valid),  64'd0);
        bus.req_valid = 4'b1100;
        cycle();
        check("wd_rewin", 64'(bus.grant_id), 64'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rg_grant_valid", 64'(bus.grant_valid),  64'd0);
        check("rg_grant_id",    64'(bus.grant_id),     64'd0);
        check("rg_ready",       64'(bus.req_ready),    64'd0);
        check("rg_count",       64'(bus.commit_count), 64'd0);
        idle();

        // 256 empty-mask commits wrap the counter
        do_reset();
        bus.req_valid[0] = 1'b1;
        bus.req_rec[0]   = 24'hABCDEF;
        repeat (768) cycle();
        check("wrap_count", 64'(bus.commit_count), 64'd0);
        check("wrap_rec_q", 64'(bus.rec_q),        64'd0);
        idle();

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int r = 0; r < int'(NREQ); r++) begin
                bus.req_valid[r] = ($urandom_range(0, 3) != 0);
                bus.req_lock[r]  = 1'($urandom);
                bus.req_rec[r]   = 24'($urandom);
                bus.req_wmask[r] = 3'($urandom);
            end
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rec_rr_arbiter.md
Name: rec_rr_arbiter

Overview:
Round-robin arbiter that shares one packed-struct record register among NREQ requesters. Each requester presents a full record plus a per-field write mask under a valid/ready handshake. The granted requester's masked fields are committed into the shared register. The block sits between requester agents and any consumer of the shared record, and is the sequencing owner of that register.

Parameters:
NREQ, 4, number of requesters (power of 2, 2..8)
MAX_BURST, 4, max consecutive commits one locked requester may take before forced release (1..15)
CNT_W, 8, width of commit counter (wraps)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester request
req_lock  input  NREQ  per-requester burst request; sampled at transfer
req_rec  input  NREQ x 24  packed array of rec_t: tag [23:16], payload.x [15:8], payload.y [7:0]
req_wmask  input  NREQ x 3  field enables: bit2 tag, bit1 x, bit0 y
req_ready  output  NREQ  one-hot handshake ready
grant_valid  output  1  a requester currently holds grant
grant_id  output  $clog2(NREQ)  index of granted requester
rec_q  output  24  shared record register (rec_t)
commit_valid  output  1  one-cycle pulse; rec_q holds the just-committed value
commit_count  output  CNT_W  number of commits since reset, mod 2^CNT_W

Behaviour:
- Reset (rst high at edge): state IDLE, rec_q=0, ptr=0, grant_id=0, grant_valid=0, commit_valid=0, commit_count=0, burst_cnt=0, req_ready=0. Reset wins over every other event, including mid-GRANT and mid-COMMIT.
- State machine:
  - IDLE: if any req_valid, the winner is the first set bit scanning ptr, ptr+1, ... mod NREQ. Register grant_id=winner, go to GRANT, burst_cnt=0. With no request, stay in IDLE.
  - GRANT: grant_valid=1. req_ready[grant_id]=req_valid[grant_id], combinational; all other ready bits are 0.
    - Transfer (valid&&ready): for each mask bit set, copy that field of req_rec[grant_id] into rec_q at this edge. Unmasked fields hold. Latch lock_q=req_lock[grant_id]. Increment burst_cnt and commit_count. Go to COMMIT.
    - Withdrawal (req_valid[grant_id]=0): no write, no count change, ptr unchanged, go to IDLE.
  - COMMIT: commit_valid=1, grant_valid=1, req_ready=0.
    - If lock_q && req_valid[grant_id] && burst_cnt<MAX_BURST: go to GRANT with the same grant_id.
    - Otherwise: ptr=(grant_id+1) mod NREQ, go to IDLE.
- Latency from IDLE: valid at cycle N -> grant_valid and ready at N+1 -> rec_q updated and commit_valid at N+2. An unlocked transaction takes 3 cycles; a locked burst adds 2 cycles per beat.
- mask=3'b000 is still a commit: counted, pulsed, rec_q unchanged.
- commit_count wraps from 2^CNT_W-1 to 0 with no flag.
- Changes to req_valid of non-granted requesters never affect the current grant.
- Outputs grant_valid, grant_id, commit_valid, rec_q and commit_count are registered or decoded from state only. req_ready is the only combinational output.

Decomposition:
- Package rec_pkg:
  - payload_t: packed struct {byte x, y}
  - rec_t: packed struct {byte tag; payload_t payload}
  - field mask bit constants: WM_TAG=2, WM_X=1, WM_Y=0
  - state enum: IDLE, GRANT, COMMIT
- Sub-module rec_rr_pick: combinational round-robin selector. Inputs: request vector and ptr. Outputs: winner index and any-request flag.

Test Plan:
- Reset; req0 rec={8'h42,8'hAA,8'h55}, mask 3'b111 -> grant_id=0 and ready[0] at N+1; rec_q=24'h42AA55, commit_valid=1, commit_count=1 at N+2.
- From reset, all four requesters valid continuously, no lock -> grant order 0,1,2,3,0, one grant every 3 cycles; commit_count=5 after 15 cycles.
- rec_q=24'h42AA55; req3 mask 3'b010, rec={8'h00,8'hFF,8'h00} -> rec_q=24'h42FF55.
- MAX_BURST=4; req1 lock and valid held, req2 valid -> 4 consecutive commits for id1 (GRANT/COMMIT alternating), then IDLE, next grant_id=2.
- req2 granted, drops valid during GRANT -> no commit_valid, rec_q and commit_count unchanged, IDLE next, req2 re-wins when it reasserts (ptr unchanged).
- rst high during GRANT -> next cycle all outputs at reset values. Separately, 256 commits with CNT_W=8 -> commit_count wraps to 0.
